// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the sound-effect scheduler.
// State encoding, widths and the volume-to-amplitude table.
package audio_pkg;

  localparam int NUM_REQ = 3;
  localparam int DIV_W   = 20;
  localparam int DUR_W   = 10;

  localparam logic [15:0] AMP_0 = 16'h0000;
  localparam logic [15:0] AMP_1 = 16'h0800;
  localparam logic [15:0] AMP_2 = 16'h2000;
  localparam logic [15:0] AMP_3 = 16'h7000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [15:0] amp_of(
    input logic [1:0] vol
  );
    logic [15:0] a;
    case (vol)
      2'd0:    a = AMP_0;
      2'd1:    a = AMP_1;
      2'd2:    a = AMP_2;
      default: a = AMP_3;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// tone_gen: square-wave generator with a registered signed sample.
// A zero half-period is a rest; enable low forces silence.
module tone_gen
  import audio_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    restart,
  input  logic                    enable,
  input  logic [DIV_W-1:0]        div,
  input  logic [1:0]              volume,
  output logic signed [15:0]      sample
);

  logic [DIV_W-1:0] cnt;
  logic             pol;
  logic [15:0]      amp;
  logic [15:0]      neg;
  logic             wrap;

  assign amp  = amp_of(volume);
  assign neg  = 16'd0 - amp;
  assign wrap = (cnt == div - DIV_W'(1));

  // half-period counter, polarity flip and sample register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      pol    <= 1'b0;
      sample <= '0;
    end else if (!enable) begin
      cnt    <= '0;
      pol    <= 1'b0;
      sample <= '0;
    end else if (restart) begin
      cnt    <= '0;
      pol    <= 1'b0;
      sample <= (div == '0) ? 16'sd0 : $signed(neg);
    end else if (div == '0) begin
      cnt    <= '0;
      pol    <= 1'b0;
      sample <= '0;
    end else if (wrap) begin
      cnt    <= '0;
      pol    <= ~pol;
      sample <= pol ? $signed(neg) : $signed(amp);
    end else begin
      cnt    <= cnt + DIV_W'(1);
      sample <= pol ? $signed(amp) : $signed(neg);
    end
  end

endmodule

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: priority arbiter and play/gap sequencer for sound effects.
// Higher requester index preempts; a silent gap follows each sound.
module sfx_scheduler
  import audio_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int GAP_MS   = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DIV_W-1:0]   note_div,
  input  logic [NUM_REQ*DUR_W-1:0]   dur_ms,
  input  logic [1:0]                 volume,
  input  logic                       abort,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       busy,
  output logic [1:0]                 grant_id,
  output logic                       done,
  output logic signed [15:0]         audio_left,
  output logic signed [15:0]         audio_right
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    P_LAST = PW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] G_LAST = DUR_W'(GAP_MS - 1);

  state_t             st;
  state_t             nxt;
  logic [1:0]         gid;
  logic [1:0]         win;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_d;
  logic [DUR_W-1:0]   dur_q;
  logic [DUR_W-1:0]   ms;
  logic [PW-1:0]      presc;
  logic               accept;
  logic               fin;
  logic               gap_end;
  logic               tick;
  logic signed [15:0] sample;

  // highest requesting index wins
  always_comb begin
    win = 2'd0;
    if (req[2])      win = 2'd2;
    else if (req[1]) win = 2'd1;
  end

  assign accept  = !abort && (|req) &&
                   (st == ST_IDLE ||
                    (st == ST_PLAY && win > gid));
  assign tick    = (presc == P_LAST);
  assign fin     = (st == ST_PLAY) && !abort &&
                   !accept && (ms == dur_q);
  assign gap_end = (st == ST_GAP) &&
                   (GAP_MS == 0 || (tick && ms == G_LAST));
  assign div_d   = accept ? note_div[win*DIV_W +: DIV_W]
                          : div_q;

  // next-state selection
  always_comb begin
    nxt = st;
    case (st)
      ST_IDLE: if (accept) nxt = ST_PLAY;
      ST_PLAY: begin
        if (abort)    nxt = ST_IDLE;
        else if (fin) nxt = ST_GAP;
      end
      ST_GAP:  if (abort || gap_end) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // state, grant latch and ack pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= ST_IDLE;
      gid   <= '0;
      div_q <= '0;
      dur_q <= '0;
      ack   <= '0;
    end else begin
      st  <= nxt;
      ack <= '0;
      if (accept) begin
        ack[win] <= 1'b1;
        gid      <= win;
        div_q    <= note_div[win*DIV_W +: DIV_W];
        dur_q    <= dur_ms[win*DUR_W +: DUR_W];
      end else if (nxt != ST_PLAY) begin
        gid <= '0;
      end
    end
  end

  // ms prescaler, cleared on every phase change or restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      ms    <= '0;
    end else if (accept || nxt != st || st == ST_IDLE) begin
      presc <= '0;
      ms    <= '0;
    end else if (tick) begin
      presc <= '0;
      ms    <= ms + DUR_W'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  tone_gen u_tone (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept),
    .enable  (nxt == ST_PLAY),
    .div     (div_d),
    .volume  (volume),
    .sample  (sample)
  );

  assign busy        = (st != ST_IDLE);
  assign grant_id    = gid;
  assign done        = fin;
  assign audio_left  = sample;
  assign audio_right = sample;

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb_sfx_scheduler: scoreboard bench with a formula-based reference.
// Expected cycles are queued by the driver and popped on negedge.
module tb_sfx_scheduler;

  localparam int TD = 10;
  localparam int GP = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [2:0]         req_r = '0;
  logic [59:0]        nd = '0;
  logic [29:0]        dm = '0;
  logic [1:0]         vol = '0;
  logic [1:0]         vol_nx = '0;
  logic               ab = 1'b0;
  logic [2:0]         ack;
  logic               busy;
  logic [1:0]         gid;
  logic               done;
  logic signed [15:0] al;
  logic signed [15:0] ar;

  sfx_scheduler #(.TICK_DIV(TD), .GAP_MS(GP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req_r),
    .note_div    (nd),
    .dur_ms      (dm),
    .volume      (vol),
    .abort       (ab),
    .ack         (ack),
    .busy        (busy),
    .grant_id    (gid),
    .done        (done),
    .audio_left  (al),
    .audio_right (ar)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ack;
    logic        busy;
    logic [1:0]  gid;
    logic        done;
    logic [15:0] s;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;
  bit   sb_on = 0;

  // reference: phase 0 idle, 1 play, 2 gap; mk = cycles into phase
  int         ph = 0;
  int         mid = 0;
  int         mk = 0;
  int         mdiv = 0;
  int         mdur = 0;
  logic [1:0] mvol = '0;
  logic [2:0] mack = '0;

  function automatic logic [15:0] amp(input logic [1:0] v);
    case (v)
      2'd0:    return 16'h0000;
      2'd1:    return 16'h0800;
      2'd2:    return 16'h2000;
      default: return 16'h7000;
    endcase
  endfunction

  task automatic model_step();
    exp_t e;
    int   top;
    bit   pre;
    top = req_r[2] ? 2 : req_r[1] ? 1 : req_r[0] ? 0 : -1;
    pre = !ab && top >= 0 &&
          (ph == 0 || (ph == 1 && top > mid));
    e.ack  = mack;
    e.busy = (ph != 0);
    e.gid  = (ph == 1) ? 2'(mid) : 2'd0;
    e.s    = 16'd0;
    if (ph == 1 && mdiv != 0)
      e.s = (((mk / mdiv) % 2) == 1) ? amp(mvol)
                                     : 16'd0 - amp(mvol);
    e.done = (ph == 1) && !ab && !pre && (mk == mdur * TD);
    q.push_back(e);
    mack = '0;
    if (ab) begin
      ph = 0;
    end else if (pre) begin
      ph   = 1;
      mid  = top;
      mk   = 0;
      mdiv = int'(nd[top*20 +: 20]);
      mdur = int'(dm[top*10 +: 10]);
      mack = 3'(1 << top);
    end else if (ph == 1) begin
      if (e.done) begin
        ph = 2;
        mk = 0;
      end else begin
        mk++;
      end
    end else if (ph == 2) begin
      if (mk + 1 >= GP * TD) ph = 0;
      else mk++;
    end
    mvol = vol;
  endtask

  task automatic tick(input logic [2:0] raise, input bit a,
                      input logic [2:0] keep);
    @(posedge clk);
    #1;
    req_r = (req_r & ~mack & keep) | raise;
    ab    = a;
    vol   = vol_nx;
    model_step();
  endtask

  task automatic run(input int n);
    repeat (n) tick(3'b000, 1'b0, 3'b111);
  endtask

  task automatic set_p(input int i, input int d, input int u);
    nd[i*20 +: 20] = 20'(d);
    dm[i*10 +: 10] = 10'(u);
  endtask

  task automatic chk(input string n, input logic [31:0] g,
                     input logic [31:0] x);
    total++;
    if (g !== x) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, g, x);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (sb_on) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow t=%0t", $time);
      end else begin
        me = q.pop_front();
        if ({ack, busy, gid, done, al} !== me || ar !== al) begin
          bad++;
          $display("FAIL cycle t=%0t got ack=%b busy=%b gid=%0d done=%b l=%h r=%h exp ack=%b busy=%b gid=%0d done=%b s=%h",
                   $time, ack, busy, gid, done, al, ar,
                   me.ack, me.busy, me.gid, me.done, me.s);
        end
      end
    end
  end

  initial begin
    logic [2:0] raise;
    bit         a;

    // reset holds everything low even with requests present
    req_r = 3'b111;
    vol   = 2'd3;
    set_p(2, 3, 1);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(gid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_left", 32'(al), 0);
    chk("rst_right", 32'(ar), 0);
    req_r = '0;
    vol   = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // two requests at once: index 1 first, index 0 after idle
    set_p(0, 4, 1);
    set_p(1, 6, 2);
    tick(3'b011, 1'b0, 3'b111);
    sb_on = 1;
    run(90);

    // basic tone at volume 2
    vol_nx = 2'd2;
    set_p(0, 5, 3);
    tick(3'b001, 1'b0, 3'b111);
    run(60);

    // preemption of a running sound by index 2
    set_p(0, 4, 5);
    tick(3'b001, 1'b0, 3'b111);
    run(15);
    set_p(2, 3, 1);
    tick(3'b100, 1'b0, 3'b111);
    run(40);

    // rest note and zero duration
    set_p(1, 0, 4);
    tick(3'b010, 1'b0, 3'b111);
    run(70);
    set_p(0, 7, 0);
    tick(3'b001, 1'b0, 3'b111);
    run(30);

    // abort beats a simultaneous request
    set_p(2, 3, 2);
    tick(3'b100, 1'b1, 3'b111);
    run(40);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      raise = '0;
      for (int j = 0; j < 3; j++) begin
        if (!req_r[j] && $urandom_range(0, 59) == 0) begin
          set_p(j,
                ($urandom_range(0, 4) == 0) ? 0
                  : int'($urandom_range(1, 12)),
                int'($urandom_range(0, 5)));
          raise[j] = 1'b1;
        end
      end
      a = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 99) == 0) vol_nx = 2'($urandom_range(0, 3));
      tick(raise, a, 3'b111);
    end

    // flush to idle
    tick(3'b000, 1'b1, 3'b000);
    run(3);
    @(negedge clk);
    #1;
    sb_on = 0;
    chk("sb_drain", 32'(q.size()), 0);

    // reset mid-play silences outputs without a clock edge
    vol = 2'd3;
    set_p(2, 3, 5);
    @(posedge clk);
    #1;
    req_r = 3'b100;
    @(posedge clk);
    #1;
    req_r = '0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(busy), 1);
    chk("pre_rst_gid", 32'(gid), 2);
    rst_n = 1'b0;
    #1;
    chk("async_left", 32'(al), 0);
    chk("async_right", 32'(ar), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_gid", 32'(gid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sfx_scheduler.md
SFX_SCHEDULER -- requirements
Module: sfx_scheduler

Interface
REQ-001 The module SHALL have parameter TICK_DIV, default 100000, meaning clk cycles per 1 ms duration tick.
REQ-002 The module SHALL have parameter GAP_MS, default 20, meaning silent ms inserted after each completed sound.
REQ-003 The module SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 The module SHALL have port req, input, 3, per-requester play request, level, held until ack; index 2 highest priority (crash), 0 lowest (music).
REQ-006 The module SHALL have port note_div, input, 60, three 20-bit half-periods in clk cycles; requester i uses bits [20i+19:20i].
REQ-007 The module SHALL have port dur_ms, input, 30, three 10-bit durations in ms; requester i uses bits [10i+9:10i].
REQ-008 The module SHALL have port volume, input, 2, live amplitude select.
REQ-009 The module SHALL have port abort, input, 1, synchronous stop request.
REQ-010 The module SHALL have port ack, output, 3, one-cycle one-hot pulse to the accepted requester.
REQ-011 The module SHALL have port busy, output, 1, high in PLAY or GAP.
REQ-012 The module SHALL have port grant_id, output, 2, index of the sound in PLAY, else 0.
REQ-013 The module SHALL have port done, output, 1, one-cycle pulse when a sound completes its duration.
REQ-014 The module SHALL have ports audio_left and audio_right, output, 16 each, signed sample to the I2S serializer, always identical.

Function
REQ-015 The FSM SHALL have states IDLE, PLAY and GAP.
REQ-016 In IDLE with any req high, the FSM SHALL grant the highest set index, pulse ack[idx] for one cycle, latch that requester's note_div/dur_ms, and enter PLAY on the next edge.
REQ-017 In PLAY, a req at an index strictly above grant_id SHALL preempt: ack that index, relatch, restart the tone and duration counters, with no done pulse for the preempted sound.
REQ-018 Requests at an index equal to or below grant_id during PLAY, and all requests during GAP, SHALL be ignored (no ack).
REQ-019 On PLAY entry, the prescaler and ms counter SHALL clear; the prescaler wraps at TICK_DIV-1 and increments the ms counter.
REQ-020 PLAY SHALL end on the cycle ms_count equals latched dur (dur 0 leaves after exactly 1 PLAY cycle), pulse done, and enter GAP.
REQ-021 GAP SHALL last GAP_MS ms via the same prescaler, then return to IDLE; GAP_MS=0 SHALL go to IDLE after 1 cycle.
REQ-022 The tone half-period counter SHALL count 0..div-1, toggle polarity and clear at div-1, with polarity cleared (negative) on each PLAY entry.
REQ-023 Latched div 0 SHALL be a rest: sample 0 for the full duration, with done still pulsed.
REQ-024 Amplitude SHALL map volume 00->0, 01->16'h0800, 10->16'h2000, 11->16'h7000; the sample SHALL be +AMP when polarity is 1 and two's-complement -AMP otherwise, registered.
REQ-025 The sample SHALL be 0 in IDLE and GAP.
REQ-026 Abort SHALL force IDLE on the next edge from any state, with samples 0 and no done pulse.
REQ-027 Abort SHALL override a same-cycle request (no ack).
REQ-028 Counters SHALL not overflow: the ms counter is 10 bits and the prescaler is ceil(log2(TICK_DIV)) bits.

Reset
REQ-029 On rst_n low, the FSM SHALL enter IDLE, all counters and latches SHALL be 0, polarity SHALL be 0, and ack, busy, grant_id, done, audio_left and audio_right SHALL all be 0.
REQ-030 Reset mid-PLAY SHALL silence the output immediately (asynchronously).
REQ-031 After reset, the first edge with rst_n high SHALL be able to accept a request.

Structure
REQ-032 Shared package audio_pkg SHALL hold the state enum, NUM_REQ=3, DIV_W=20, DUR_W=10 and the four amplitude constants.
REQ-033 There SHALL be one sub-module, tone_gen (half-period counter, polarity, amplitude mapping, sample register), with restart, enable, div and volume inputs.
REQ-034 Arbitration, the FSM and the prescaler SHALL stay in sfx_scheduler.

Verification (TICK_DIV=10, GAP_MS=2)
REQ-035 req=3'b011 in IDLE -> ack=3'b010 only; grant_id=1; req[0] not acked until IDLE returns.
REQ-036 req0 with div=5, dur=3, volume=10 -> sample alternates -0x2000/+0x2000 every 5 cycles; done exactly 30 PLAY cycles after entry; then 20 zero cycles in GAP; then IDLE.
REQ-037 Playing id 0, req2 asserted -> ack=3'b100 next cycle, grant_id=2, polarity restarts negative, no done for id 0.
REQ-038 div=0, dur=4 -> samples all 0 for 40 cycles, done pulses.
REQ-039 dur=0 -> one PLAY cycle, done, GAP.
REQ-040 abort concurrent with req2 in IDLE -> no ack, samples 0.
REQ-041 rst_n low mid-PLAY -> outputs 0 with no clock edge.
